// File: rtl/leibniz_pi_engine.sv
// Leibniz-series pi approximation: one shared serial restoring divider produces
// floor(4*2^FRAC_BITS / (2k+1)) per term, and the signed sum is accumulated into result.
module leibniz_pi_engine #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned FRAC_BITS = 32,
  parameter int unsigned TERM_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [TERM_BITS-1:0] n_terms,
  output logic                 busy,
  output logic                 done,
  output logic                 result_valid,
  output logic [WIDTH-1:0]     result,
  output logic [TERM_BITS-1:0] term_idx
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] NUMER = WIDTH'(4) << FRAC_BITS;

  if (FRAC_BITS + 4 > WIDTH) begin : g_bad_frac
    $error("leibniz_pi_engine: FRAC_BITS must be <= WIDTH-4");
  end
  if (TERM_BITS + 1 > WIDTH) begin : g_bad_term
    $error("leibniz_pi_engine: TERM_BITS+1 must be <= WIDTH");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIVIDE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [TERM_BITS-1:0] r_n_terms;
  logic [TERM_BITS-1:0] r_term_idx;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_dvd;
  logic [WIDTH-1:0]     r_dvsr;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_valid;

  logic [WIDTH:0]       w_rem_shift;
  logic                 w_sub_ok;
  logic                 w_last_term;

  // Shifted partial remainder needs one extra bit before the trial subtract.
  assign w_rem_shift = {r_rem, r_dvd[WIDTH-1]};
  assign w_sub_ok    = (w_rem_shift >= {1'b0, r_dvsr});
  assign w_last_term = (r_term_idx == r_n_terms - TERM_BITS'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = (n_terms == '0) ? S_DONE : S_LOAD;
      S_LOAD:   w_next = S_DIVIDE;
      S_DIVIDE: if (r_bit_cnt == CNT_W'(1)) w_next = S_ACCUM;
      S_ACCUM:  w_next = w_last_term ? S_DONE : S_LOAD;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath and registered status flags, all keyed off the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_n_terms  <= '0;
      r_term_idx <= '0;
      r_acc      <= '0;
      r_rem      <= '0;
      r_dvd      <= '0;
      r_dvsr     <= '0;
      r_bit_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n_terms  <= n_terms;
            r_acc      <= '0;
            r_term_idx <= '0;
            r_valid    <= 1'b0;
          end
        end
        S_LOAD: begin
          r_rem     <= '0;
          r_dvd     <= NUMER;
          r_dvsr    <= WIDTH'({r_term_idx, 1'b1});
          r_bit_cnt <= CNT_W'(WIDTH);
        end
        S_DIVIDE: begin
          if (w_sub_ok) begin
            r_rem <= WIDTH'(w_rem_shift - {1'b0, r_dvsr});
          end else begin
            r_rem <= WIDTH'(w_rem_shift);
          end
          r_dvd     <= {r_dvd[WIDTH-2:0], w_sub_ok};
          r_bit_cnt <= r_bit_cnt - CNT_W'(1);
        end
        S_ACCUM: begin
          r_acc <= r_term_idx[0] ? (r_acc - r_dvd) : (r_acc + r_dvd);
          if (!w_last_term) r_term_idx <= r_term_idx + TERM_BITS'(1);
        end
        default: ;
      endcase
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);
      if (w_next == S_DONE) r_valid <= 1'b1;
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign result_valid = r_valid;
  assign result       = r_acc;
  assign term_idx     = r_term_idx;

endmodule

// File: tb/tb_leibniz_pi_engine.sv
// Bench for leibniz_pi_engine: a WIDTH=16/FRAC_BITS=8 instance and a default instance,
// checked against a direct-division series model through result scoreboards.
module tb_leibniz_pi_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        s_start = 1'b0;
  logic [15:0] s_n = '0;
  logic        busy16, done16, valid16;
  logic [15:0] res16, idx16;

  logic        m_start = 1'b0;
  logic [15:0] m_n = '0;
  logic        busy64, done64, valid64;
  logic [63:0] res64;
  logic [15:0] idx64;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] q16[$];
  logic [63:0] q64[$];

  always #5 clk = ~clk;

  leibniz_pi_engine #(.WIDTH(16), .FRAC_BITS(8), .TERM_BITS(8 + 8)) u_dut16 (
    .clk(clk), .reset(reset), .start(s_start), .n_terms(s_n),
    .busy(busy16), .done(done16), .result_valid(valid16),
    .result(res16), .term_idx(idx16)
  );

  leibniz_pi_engine u_dut64 (
    .clk(clk), .reset(reset), .start(m_start), .n_terms(m_n),
    .busy(busy64), .done(done64), .result_valid(valid64),
    .result(res64), .term_idx(idx64)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input int n, input int w, input int f);
    logic [63:0] acc, num, q;
    acc = '0;
    num = 64'd4 << f;
    for (int k = 0; k < n; k++) begin
      q = num / 64'(2 * k + 1);
      if (k % 2 == 1) acc = acc - q;
      else            acc = acc + q;
    end
    if (w < 64) acc = acc & ((64'd1 << w) - 64'd1);
    return acc;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start into the 16-bit instance; returns in cycle t+1.
  task automatic start16(input int n);
    s_n = 16'(n);
    s_start = 1'b1;
    q16.push_back(model(n, 16, 8));
    step();
    s_start = 1'b0;
  endtask

  task automatic wait16(output int lat);
    lat = 1;
    while (done16 !== 1'b1 && lat < 2000) begin
      step();
      lat++;
    end
  endtask

  task automatic wait64(output int lat);
    lat = 1;
    while (done64 !== 1'b1 && lat < 2000) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_tests++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL rst_busy16: got %b expected 0", busy16); end
    n_tests++; if (done16 !== 1'b0) begin n_fail++; $display("FAIL rst_done16: got %b expected 0", done16); end
    n_tests++; if (valid16 !== 1'b0) begin n_fail++; $display("FAIL rst_valid16: got %b expected 0", valid16); end
    n_tests++; if (res16 !== 16'h0) begin n_fail++; $display("FAIL rst_result16: got %0h expected 0", res16); end
    n_tests++; if (idx16 !== 16'h0) begin n_fail++; $display("FAIL rst_idx16: got %0h expected 0", idx16); end
    n_tests++; if ({busy64, done64, valid64} !== 3'b000) begin n_fail++; $display("FAIL rst_flags64: got %b expected 000", {busy64, done64, valid64}); end
    n_tests++; if (res64 !== 64'h0 || idx64 !== 16'h0) begin n_fail++; $display("FAIL rst_result64: got %0h/%0h expected 0/0", res64, idx64); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_one_term();
    int lat;
    logic [63:0] exp;
    start16(1);
    wait16(lat);
    n_tests++; if (lat !== 19) begin n_fail++; $display("FAIL one_latency: got %0d expected 19", lat); end
    exp = q16.pop_front();
    n_tests++; if ({48'h0, res16} !== exp || exp !== 64'd1024) begin n_fail++; $display("FAIL one_result: got %0d expected 1024", res16); end
    n_tests++; if (valid16 !== 1'b1) begin n_fail++; $display("FAIL one_valid: got %b expected 1", valid16); end
    step();
    n_tests++; if (done16 !== 1'b0 || valid16 !== 1'b1 || busy16 !== 1'b0) begin
      n_fail++; $display("FAIL one_after_done: got done=%b valid=%b busy=%b expected 0 1 0", done16, valid16, busy16);
    end
  endtask

  task automatic test_four_terms();
    logic [63:0] exp;
    s_n = 16'd4;
    s_start = 1'b1;
    q16.push_back(model(4, 16, 8));
    step();
    s_start = 1'b0;
    for (int c = 1; c <= 73; c++) begin
      if (c > 1) step();
      if (c > 1 && c % 18 == 1) begin
        exp = model(c / 18, 16, 8);
        n_tests++; if ({48'h0, res16} !== exp) begin n_fail++; $display("FAIL four_partial_%0d: got %0d expected %0d", c / 18, res16, exp); end
      end
      if (c == 72) begin
        n_tests++; if (done16 !== 1'b0) begin n_fail++; $display("FAIL four_early_done: got %b expected 0", done16); end
      end
    end
    n_tests++; if (done16 !== 1'b1) begin n_fail++; $display("FAIL four_done: got %b expected 1", done16); end
    n_tests++; if (idx16 !== 16'd3) begin n_fail++; $display("FAIL four_idx: got %0d expected 3", idx16); end
    exp = q16.pop_front();
    n_tests++; if ({48'h0, res16} !== exp || exp !== 64'd741) begin n_fail++; $display("FAIL four_result: got %0d expected 741", res16); end
    step();
  endtask

  task automatic test_zero_terms();
    logic [63:0] exp;
    start16(0);
    exp = q16.pop_front();
    n_tests++; if (done16 !== 1'b1 || busy16 !== 1'b1) begin n_fail++; $display("FAIL zero_done: got done=%b busy=%b expected 1 1", done16, busy16); end
    n_tests++; if ({48'h0, res16} !== exp) begin n_fail++; $display("FAIL zero_result: got %0d expected %0d", res16, exp); end
    step();
    n_tests++; if (busy16 !== 1'b0 || done16 !== 1'b0 || valid16 !== 1'b1) begin
      n_fail++; $display("FAIL zero_after: got busy=%b done=%b valid=%b expected 0 0 1", busy16, done16, valid16);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0] exp;
    start16(4);
    lat = 1;
    while (done16 !== 1'b1 && lat < 2000) begin
      if (lat == 5) begin
        s_n = 16'd3;
        s_start = 1'b1;
      end else begin
        s_start = 1'b0;
      end
      step();
      lat++;
    end
    s_start = 1'b0;
    n_tests++; if (lat !== 73) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 73", lat); end
    exp = q16.pop_front();
    n_tests++; if ({48'h0, res16} !== exp) begin n_fail++; $display("FAIL busy_start_result: got %0d expected %0d", res16, exp); end
    step();
    start16(1);
    n_tests++; if (busy16 !== 1'b1 || valid16 !== 1'b0) begin n_fail++; $display("FAIL restart_accept: got busy=%b valid=%b expected 1 0", busy16, valid16); end
    wait16(lat);
    n_tests++; if (lat !== 19) begin n_fail++; $display("FAIL restart_latency: got %0d expected 19", lat); end
    exp = q16.pop_front();
    n_tests++; if ({48'h0, res16} !== exp) begin n_fail++; $display("FAIL restart_result: got %0d expected %0d", res16, exp); end
    step();
  endtask

  task automatic test_reset_mid_divide();
    int lat;
    logic [63:0] exp;
    s_n = 16'd4;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    repeat (44) step();
    n_tests++; if (busy16 !== 1'b1 || idx16 !== 16'd2) begin n_fail++; $display("FAIL mid_state: got busy=%b idx=%0d expected 1 2", busy16, idx16); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_tests++; if (busy16 !== 1'b0 || valid16 !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flags: got busy=%b valid=%b expected 0 0", busy16, valid16); end
    n_tests++; if (res16 !== 16'h0 || idx16 !== 16'h0) begin n_fail++; $display("FAIL mid_reset_regs: got result=%0d idx=%0d expected 0 0", res16, idx16); end
    start16(2);
    wait16(lat);
    n_tests++; if (lat !== 37) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 37", lat); end
    exp = q16.pop_front();
    n_tests++; if ({48'h0, res16} !== exp || exp !== 64'd683) begin n_fail++; $display("FAIL post_reset_result: got %0d expected 683", res16); end
    step();
  endtask

  task automatic test_random_terms();
    int lat, n;
    logic [63:0] exp;
    for (int i = 0; i < 4; i++) begin
      n = int'($urandom_range(1, 9));
      start16(n);
      wait16(lat);
      n_tests++; if (lat !== 1 + 18 * n) begin n_fail++; $display("FAIL rand_latency_n%0d: got %0d expected %0d", n, lat, 1 + 18 * n); end
      exp = q16.pop_front();
      n_tests++; if ({48'h0, res16} !== exp) begin n_fail++; $display("FAIL rand_result_n%0d: got %0d expected %0d", n, res16, exp); end
      step();
    end
  endtask

  task automatic test_default_params();
    int lat;
    logic [63:0] exp;
    for (int n = 1; n <= 2; n++) begin
      m_n = 16'(n);
      m_start = 1'b1;
      q64.push_back(model(n, 64, 32));
      step();
      m_start = 1'b0;
      wait64(lat);
      n_tests++; if (lat !== 1 + 66 * n) begin n_fail++; $display("FAIL w64_latency_n%0d: got %0d expected %0d", n, lat, 1 + 66 * n); end
      exp = q64.pop_front();
      n_tests++; if (res64 !== exp) begin n_fail++; $display("FAIL w64_result_n%0d: got %0h expected %0h", n, res64, exp); end
      if (n == 1) begin
        n_tests++; if (res64 !== 64'h0000_0004_0000_0000) begin n_fail++; $display("FAIL w64_const_n1: got %0h expected 400000000", res64); end
      end else begin
        n_tests++; if (res64 !== 64'h0000_0002_AAAA_AAAB) begin n_fail++; $display("FAIL w64_const_n2: got %0h expected 2aaaaaaab", res64); end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_one_term();
    test_four_terms();
    test_zero_terms();
    test_back_to_back();
    test_reset_mid_divide();
    test_random_terms();
    test_default_params();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/leibniz_pi_engine.md
Name: leibniz_pi_engine

Overview:
- Computes a fixed-point approximation of pi with the Leibniz series: S = Σ_{k=0}^{n-1} (-1)^k · floor(4·2^FRAC_BITS / (2k+1)).
- A single serial radix-2 restoring divider is shared across terms, and a start/busy/done handshake controls each run.
- Generalises the earlier fixed 4-term, 8-divider pi pipeline in three ways: runtime-selectable term count, parametrised width and fraction bits, and a defined reset/restart behaviour.
- Sits behind the SWI/LED/LCD top level; the result drives the LCD.

Parameters:
- WIDTH, 64: bits of divider datapath, accumulator and result.
- FRAC_BITS, 32: fraction bits of result. Elaboration must fail unless FRAC_BITS <= WIDTH-4.
- TERM_BITS, 16: width of term count and term index.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request a new run. Sampled only in IDLE.
- n_terms, input, TERM_BITS: number of series terms. Latched when start is accepted.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when the result becomes final.
- result_valid, output, 1: high from done until the next accepted start or reset.
- result, output, WIDTH: signed two's-complement partial/final sum, Q(WIDTH-FRAC_BITS).FRAC_BITS.
- term_idx, output, TERM_BITS: index k of the term being processed.

Behaviour:
- Reset (synchronous, active-high): next state IDLE. Values after reset:
  - busy=0, done=0, result_valid=0
  - result=0, term_idx=0
  - divider registers cleared
- Reset overrides start and any in-flight operation, including mid-DIVIDE. The partial sum is discarded.
- Constants:
  - Numerator N = 4<<FRAC_BITS (unsigned, WIDTH bits).
  - Denominator D_k = 2k+1, computed in WIDTH bits; k is zero-extended.
- States and transitions:
  - IDLE: when start=1, latch n_terms, clear the accumulator, term_idx=0, result_valid=0. Go to DONE if n_terms=0, else LOAD.
  - LOAD (1 cycle): load remainder=0, dividend shift register=N, divisor=D_k, bit counter=WIDTH. Go to DIVIDE.
  - DIVIDE (WIDTH cycles): each cycle, shift {remainder, dividend} left by 1. If remainder >= divisor, subtract and set quotient LSB=1, else 0. After WIDTH cycles go to ACCUM.
  - ACCUM (1 cycle): accumulator += quotient if k is even, -= quotient if k is odd (WIDTH-bit wraparound arithmetic; in range by construction, since 0 < S <= N). If k = n_terms-1 go to DONE, else increment term_idx and go to LOAD.
  - DONE (1 cycle): done=1, result_valid=1. Go to IDLE.
- result mirrors the accumulator every cycle; partial sums are visible while busy.
- Latency:
  - start sampled at cycle t → done high at cycle t+1+n·(WIDTH+2).
  - n_terms=0 → done at t+1 with result=0.
- start while busy is ignored, and n_terms changes mid-run are ignored.
- Simultaneous start and DONE: start is not seen until IDLE, one cycle after done.
- Maximum n_terms = 2^TERM_BITS-1. D_k never overflows because TERM_BITS+1 <= WIDTH.
- Division is exact floor division; no rounding.

Test Plan:
- WIDTH=16, FRAC_BITS=8, n_terms=1, start at cycle t → done at t+19, result=1024 (0x0400), result_valid=1.
- WIDTH=16, FRAC_BITS=8, n_terms=4 → result after each ACCUM: 1024, 683, 887, 741. Final result=741, done at t+73, term_idx=3.
- Default parameters, n_terms=1 → result=0x0000_0004_0000_0000 at t+67. With n_terms=2 → result=0x2_AAAA_AAAB (4·2^32 − floor(4·2^32/3)).
- n_terms=0 → done at t+1, result=0, busy high for exactly one cycle.
- Reset asserted mid-DIVIDE of term 2 → next cycle busy=0, result=0, result_valid=0, term_idx=0. A new start with n_terms=2 then gives 683 (WIDTH=16 configuration).
- Second start pulse while busy with n_terms=3 → ignored; the first run completes with n_terms=4 → 741. A start one cycle after done is accepted.
